// File: rtl/axil_regs_fifo_if.sv
// AXI-Lite and AXI-Stream interface bundles used by the AES-UART register file.
// The AXI-Lite bundle is split into write and read modports so each channel group can be bound separately.

interface taxi_axil_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;

   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;

   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport wr_slv (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output awready, wready, bresp, bvalid
   );
   modport wr_mst (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  awready, wready, bresp, bvalid
   );
   modport rd_slv (
      input  araddr, arvalid, rready,
      output arready, rdata, rresp, rvalid
   );
   modport rd_mst (
      output araddr, arvalid, rready,
      input  arready, rdata, rresp, rvalid
   );
endinterface

interface taxi_axis_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;

   modport src (output tdata, tvalid, input tready);
   modport snk (input tdata, tvalid, output tready);
endinterface

// File: rtl/axil_regs_fifo.sv
// AXI-Lite register file for the AES-UART core: control/key registers, TX/RX character FIFOs,
// sticky event flags with W1C clear and flush, and a registered maskable interrupt.

module axil_regs_fifo #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int CHAR_W    = 8,
   parameter int TX_DEPTH  = 16,
   parameter int RX_DEPTH  = 16,
   parameter int RX_THRESH = 8,
   parameter int NKEY      = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   taxi_axil_if.wr_slv            s_axil_wr,
   taxi_axil_if.rd_slv            s_axil_rd,
   output logic [31:0]            o_cr1,
   output logic [31:0]            o_cr2,
   output logic [31:0]            o_brr,
   input  logic [31:0]            i_isr,
   output logic [NKEY-1:0][31:0]  o_ekr,
   output logic [NKEY-1:0][31:0]  o_dkr,
   output logic                   o_irq,
   taxi_axis_if.snk               s_axis_rdr,
   taxi_axis_if.src               m_axis_tdr
);
   localparam int TX_AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
   localparam int RX_AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

   localparam logic [5:0] A_CR1 = 6'h00;
   localparam logic [5:0] A_CR2 = 6'h01;
   localparam logic [5:0] A_BRR = 6'h02;
   localparam logic [5:0] A_ISR = 6'h03;
   localparam logic [5:0] A_ICR = 6'h04;
   localparam logic [5:0] A_RDR = 6'h05;
   localparam logic [5:0] A_TDR = 6'h06;
   localparam logic [5:0] A_IER = 6'h07;
   localparam logic [5:0] A_FSR = 6'h08;
   localparam logic [5:0] A_EKR = 6'h10;
   localparam logic [5:0] A_DKR = 6'h18;

   // Only pe, fe, ore, txovf and rxudf are stored; the other ISR bits are live status.
   localparam logic [7:0] STICKY_MASK = 8'hC7;

   localparam logic [TX_AW:0] TX_CNT_FULL = (TX_AW + 1)'(TX_DEPTH);
   localparam logic [RX_AW:0] RX_CNT_FULL = (RX_AW + 1)'(RX_DEPTH);
   localparam logic [RX_AW:0] RX_CNT_TH   = (RX_AW + 1)'(RX_THRESH);

   function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
      end
      return res;
   endfunction

   // Handshake enables stay low for the first cycle out of reset so no ready can pulse while reset is held.
   logic run_q;

   logic              wr_acc, rd_acc;
   logic [5:0]        wr_idx, rd_idx;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;

   logic              bvalid_q, bvalid_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d, rd_mux;

   logic [31:0] cr1_q, cr1_d;
   logic [31:0] cr2_q, cr2_d;
   logic [31:0] brr_q, brr_d;
   logic [31:0] ier_q, ier_d;
   logic [31:0] icr;

   logic [7:0]  sticky_q, sticky_d, sticky_set, isr_val;
   logic        irq_q, irq_d;
   logic [31:0] fsr_val;

   logic [CHAR_W-1:0] tx_mem [TX_DEPTH];
   logic [TX_AW-1:0]  tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
   logic [TX_AW:0]    tx_count_q, tx_count_d;
   logic              tx_empty, tx_full, tx_wr_req, tx_push, tx_pop, tx_flush, tx_ovf_set;

   logic [CHAR_W-1:0] rx_mem [RX_DEPTH];
   logic [RX_AW-1:0]  rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
   logic [RX_AW:0]    rx_count_q, rx_count_d;
   logic              rx_empty, rx_full, rx_push, rx_pop_req, rx_pop, rx_flush, rx_udf_set;
   logic              rxne, rxth;
   logic [CHAR_W-1:0] rx_head;

   assign wdata  = s_axil_wr.wdata;
   assign wstrb  = s_axil_wr.wstrb;
   assign wr_idx = s_axil_wr.awaddr[7:2];
   assign rd_idx = s_axil_rd.araddr[7:2];

   assign wr_acc = run_q && s_axil_wr.awvalid && s_axil_wr.wvalid && !bvalid_q;
   assign rd_acc = run_q && s_axil_rd.arvalid && !rvalid_q;

   assign s_axil_wr.awready = wr_acc;
   assign s_axil_wr.wready  = wr_acc;
   assign s_axil_wr.bvalid  = bvalid_q;
   assign s_axil_wr.bresp   = 2'b00;
   assign s_axil_rd.arready = rd_acc;
   assign s_axil_rd.rvalid  = rvalid_q;
   assign s_axil_rd.rdata   = rdata_q;
   assign s_axil_rd.rresp   = 2'b00;

   assign o_cr1 = cr1_q;
   assign o_cr2 = cr2_q;
   assign o_brr = brr_q;
   assign o_irq = irq_q;

   always_comb begin
      cr1_d = cr1_q;
      cr2_d = cr2_q;
      brr_d = brr_q;
      ier_d = ier_q;
      icr   = '0;
      if (wr_acc) begin
         case (wr_idx)
            A_CR1:   cr1_d = merge_strb(cr1_q, wdata, wstrb);
            A_CR2:   cr2_d = merge_strb(cr2_q, wdata, wstrb);
            A_BRR:   brr_d = merge_strb(brr_q, wdata, wstrb);
            A_IER:   ier_d = merge_strb(ier_q, wdata, wstrb);
            A_ICR:   icr   = merge_strb(32'h0, wdata, wstrb);
            default: ;
         endcase
      end
   end

   for (genvar gi = 0; gi < NKEY; gi++) begin : g_key
      logic [31:0] ekr_q, dkr_q;
      logic        ekr_we, dkr_we;

      assign ekr_we = wr_acc && (wr_idx == (A_EKR + 6'(gi)));
      assign dkr_we = wr_acc && (wr_idx == (A_DKR + 6'(gi)));

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            ekr_q <= '0;
            dkr_q <= '0;
         end else begin
            if (ekr_we) ekr_q <= merge_strb(ekr_q, wdata, wstrb);
            if (dkr_we) dkr_q <= merge_strb(dkr_q, wdata, wstrb);
         end
      end

      assign o_ekr[gi] = ekr_q;
      assign o_dkr[gi] = dkr_q;
   end

   // TX FIFO: first-word fall-through towards the UART transmitter.
   assign tx_empty   = (tx_count_q == '0);
   assign tx_full    = (tx_count_q == TX_CNT_FULL);
   assign tx_wr_req  = wr_acc && (wr_idx == A_TDR) && wstrb[0];
   assign tx_push    = tx_wr_req && !tx_full;
   assign tx_ovf_set = tx_wr_req && tx_full;
   assign tx_pop     = !tx_empty && m_axis_tdr.tready;
   assign tx_flush   = icr[8];

   assign m_axis_tdr.tvalid = !tx_empty;
   assign m_axis_tdr.tdata  = tx_mem[tx_rptr_q];

   always_comb begin
      tx_wptr_d  = tx_wptr_q;
      tx_rptr_d  = tx_rptr_q;
      tx_count_d = tx_count_q;
      if (tx_flush) begin
         tx_wptr_d  = '0;
         tx_rptr_d  = '0;
         tx_count_d = '0;
      end else begin
         if (tx_push) tx_wptr_d = tx_wptr_q + TX_AW'(1);
         if (tx_pop)  tx_rptr_d = tx_rptr_q + TX_AW'(1);
         case ({tx_push, tx_pop})
            2'b10:   tx_count_d = tx_count_q + (TX_AW + 1)'(1);
            2'b01:   tx_count_d = tx_count_q - (TX_AW + 1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wptr_q] <= wdata[CHAR_W-1:0];
   end

   // RX FIFO: a flush in the same cycle as an incoming beat discards that beat.
   assign rx_empty   = (rx_count_q == '0);
   assign rx_full    = (rx_count_q == RX_CNT_FULL);
   assign rx_flush   = icr[9];
   assign rx_push    = s_axis_rdr.tvalid && !rx_full && !rx_flush;
   assign rx_pop_req = rd_acc && (rd_idx == A_RDR);
   assign rx_pop     = rx_pop_req && !rx_empty;
   assign rx_udf_set = rx_pop_req && rx_empty;
   assign rx_head    = rx_mem[rx_rptr_q];
   assign rxne       = !rx_empty;
   assign rxth       = (rx_count_q >= RX_CNT_TH);

   assign s_axis_rdr.tready = !rx_full;

   always_comb begin
      rx_wptr_d  = rx_wptr_q;
      rx_rptr_d  = rx_rptr_q;
      rx_count_d = rx_count_q;
      if (rx_flush) begin
         rx_wptr_d  = '0;
         rx_rptr_d  = '0;
         rx_count_d = '0;
      end else begin
         if (rx_push) rx_wptr_d = rx_wptr_q + RX_AW'(1);
         if (rx_pop)  rx_rptr_d = rx_rptr_q + RX_AW'(1);
         case ({rx_push, rx_pop})
            2'b10:   rx_count_d = rx_count_q + (RX_AW + 1)'(1);
            2'b01:   rx_count_d = rx_count_q - (RX_AW + 1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wptr_q] <= s_axis_rdr.tdata;
   end

   // A set landing in the same cycle as its W1C clear must win, so OR the set in after masking.
   assign sticky_set = {rx_udf_set, tx_ovf_set, 3'b000, i_isr[2:0]};
   assign sticky_d   = ((sticky_q & ~icr[7:0]) | sticky_set) & STICKY_MASK;
   assign isr_val    = {sticky_q[7:6], rxth, tx_empty, rxne, sticky_q[2:0]};
   assign irq_d      = |(isr_val & ier_q[7:0]);

   assign fsr_val = {14'h0, rx_full, tx_full, 8'(rx_count_q), 8'(tx_count_q)};

   always_comb begin
      rd_mux = '0;
      case (rd_idx)
         A_CR1: rd_mux = cr1_q;
         A_CR2: rd_mux = cr2_q;
         A_BRR: rd_mux = brr_q;
         A_ISR: rd_mux = {24'h0, isr_val};
         A_RDR: rd_mux = rx_empty ? '0 : DATA_W'(rx_head);
         A_IER: rd_mux = ier_q;
         A_FSR: rd_mux = fsr_val;
         default: begin
            if (rd_idx[5:3] == 3'b010 && int'(rd_idx[2:0]) < NKEY) rd_mux = o_ekr[rd_idx[2:0]];
            if (rd_idx[5:3] == 3'b011 && int'(rd_idx[2:0]) < NKEY) rd_mux = o_dkr[rd_idx[2:0]];
         end
      endcase
   end

   assign bvalid_d = wr_acc ? 1'b1 : (bvalid_q && !s_axil_wr.bready);
   assign rvalid_d = rd_acc ? 1'b1 : (rvalid_q && !s_axil_rd.rready);
   assign rdata_d  = rd_acc ? rd_mux : rdata_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q      <= 1'b0;
         bvalid_q   <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         cr1_q      <= '0;
         cr2_q      <= '0;
         brr_q      <= '0;
         ier_q      <= '0;
         sticky_q   <= '0;
         irq_q      <= 1'b0;
         tx_wptr_q  <= '0;
         tx_rptr_q  <= '0;
         tx_count_q <= '0;
         rx_wptr_q  <= '0;
         rx_rptr_q  <= '0;
         rx_count_q <= '0;
      end else begin
         run_q      <= 1'b1;
         bvalid_q   <= bvalid_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         cr1_q      <= cr1_d;
         cr2_q      <= cr2_d;
         brr_q      <= brr_d;
         ier_q      <= ier_d;
         sticky_q   <= sticky_d;
         irq_q      <= irq_d;
         tx_wptr_q  <= tx_wptr_d;
         tx_rptr_q  <= tx_rptr_d;
         tx_count_q <= tx_count_d;
         rx_wptr_q  <= rx_wptr_d;
         rx_rptr_q  <= rx_rptr_d;
         rx_count_q <= rx_count_d;
      end
   end

   logic unused_ok;
   assign unused_ok = ^{i_isr[31:3], s_axil_wr.awaddr[ADDR_W-1:8], s_axil_wr.awaddr[1:0],
                        s_axil_rd.araddr[ADDR_W-1:8], s_axil_rd.araddr[1:0], icr[31:10]};

endmodule
